// File: rtl/control_sequencer_if.sv
// Strobe and handshake bundle between the hardwired control sequencer and its datapath.
// The sequencer is the master: it drives every strobe and samples run, mem_rdy and ir.
interface control_sequencer_if #(
  parameter int OP_W  = 5,
  parameter int REG_W = 4
);
  logic             run;
  logic             mem_rdy;
  logic [31:0]      ir;

  logic             PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic             ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
  logic             reg_out_en, reg_in_en;
  logic [REG_W-1:0] reg_sel;
  logic [OP_W-1:0]  opcode;
  logic             done, halted, fault;

  modport master (
    input  run, mem_rdy, ir,
    output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
    output ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
    output reg_out_en, reg_in_en, reg_sel, opcode,
    output done, halted, fault
  );

  modport slave (
    output run, mem_rdy, ir,
    input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
    input  ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
    input  reg_out_en, reg_in_en, reg_sel, opcode,
    input  done, halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) then three-operand ALU or MUL/DIV
// execution (T3-T6), with sticky HALT and FAULT traps that only clear can leave.
module control_sequencer #(
  parameter int OP_W  = 5,
  parameter int REG_W = 4
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  localparam int RA_LSB = 32 - OP_W - REG_W;
  localparam int RB_LSB = RA_LSB - REG_W;
  localparam int RC_LSB = RB_LSB - REG_W;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT, ST_FAULT
  } state_t;

  state_t           state;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] ra, rb, rc;
  logic             is_alu, is_wide, is_halt;
  logic             unused_ir;

  assign op        = bus.ir[31 -: OP_W];
  assign ra        = bus.ir[RA_LSB +: REG_W];
  assign rb        = bus.ir[RB_LSB +: REG_W];
  assign rc        = bus.ir[RC_LSB +: REG_W];
  assign unused_ir = ^bus.ir[RC_LSB-1:0];

  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_wide = (op == OP_MUL) || (op == OP_DIV);
  assign is_halt = (op == OP_HALT);

  // NOTE: state is sequential, so it takes non-blocking assignments only; clear is
  // sampled on the edge and overrides run/mem_rdy from every state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (bus.run) state <= ST_T0;
        ST_T0:    state <= ST_T1;
        ST_T1:    if (bus.mem_rdy) state <= ST_T2;
        ST_T2:    state <= ST_T3;
        ST_T3: begin
          if (is_alu || is_wide) state <= ST_T4;
          else if (is_halt)      state <= ST_HALT;
          else                   state <= ST_FAULT;
        end
        ST_T4:    state <= ST_T5;
        ST_T5: begin
          if (is_wide) state <= ST_T6;
          else         state <= bus.run ? ST_T0 : ST_IDLE;
        end
        ST_T6:    state <= bus.run ? ST_T0 : ST_IDLE;
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from state plus the IR fields: IR is only loaded at the T2->T3
  // edge, so T3 outputs cannot be precomputed into registers a cycle early.
  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    bus.PCout      = 1'b0;
    bus.PCin       = 1'b0;
    bus.IncPC      = 1'b0;
    bus.MARin      = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.ZLowIn     = 1'b0;
    bus.ZHighIn    = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.reg_out_en = 1'b0;
    bus.reg_in_en  = 1'b0;
    bus.reg_sel    = '0;
    bus.opcode     = '0;
    bus.done       = 1'b0;
    bus.halted     = 1'b0;
    bus.fault      = 1'b0;

    unique case (state)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.PCin  = 1'b1;
      end
      ST_T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (is_alu || is_wide) begin
          bus.reg_out_en = 1'b1;
          bus.reg_sel    = rb;
          bus.Yin        = 1'b1;
        end
      end
      ST_T4: begin
        bus.reg_out_en = 1'b1;
        bus.reg_sel    = rc;
        bus.opcode     = op;
        bus.ZLowIn     = 1'b1;
        bus.ZHighIn    = 1'b1;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (is_wide) begin
          bus.LOin = 1'b1;
        end else begin
          bus.reg_in_en = 1'b1;
          bus.reg_sel   = ra;
          bus.done      = 1'b1;
        end
      end
      ST_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      ST_HALT:  bus.halted = 1'b1;
      ST_FAULT: bus.fault  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a stimulus process plans each instruction's
// strobe trace and architectural result; a monitor pops and compares every cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic       PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
    logic       ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
    logic       reg_out_en, reg_in_en;
    logic [3:0] reg_sel;
    logic [4:0] opcode;
    logic       done, halted, fault;
  } out_t;

  typedef struct {
    out_t e;
    logic mr;
  } cyc_t;

  typedef struct {
    logic        wide;
    logic [3:0]  ra;
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic clock = 1'b0;
  logic clear;
  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];
  res_t res_q[$];
  bit   res_pending = 1'b0;

  logic [31:0] model_regs [16];
  logic [31:0] init_val   [16];
  logic        init_regs;

  // Minimal datapath that obeys the strobes, so instruction results can be observed.
  logic [31:0] regs [16];
  logic [31:0] y_r, zlo, zhi, hi_r, lo_r, dbus;
  logic [63:0] alu;

  always_comb begin
    dbus = '0;
    if (bus.reg_out_en)    dbus = regs[bus.reg_sel];
    else if (bus.Zlowout)  dbus = zlo;
    else if (bus.Zhighout) dbus = zhi;
  end

  always_comb begin
    alu = '0;
    case (bus.opcode)
      5'd3:    alu = {32'd0, y_r + dbus};
      5'd4:    alu = {32'd0, y_r - dbus};
      5'd5:    alu = {32'd0, y_r & dbus};
      5'd6:    alu = {32'd0, y_r | dbus};
      5'd15:   alu = {32'd0, y_r} * {32'd0, dbus};
      5'd16:   alu = (dbus == 32'd0) ? 64'd0 : {y_r % dbus, y_r / dbus};
      default: alu = '0;
    endcase
  end

  always @(posedge clock) begin
    if (init_regs) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_val[i];
    end else if (bus.reg_in_en) begin
      regs[bus.reg_sel] <= dbus;
    end
    if (bus.Yin)     y_r  <= dbus;
    if (bus.ZLowIn)  zlo  <= alu[31:0];
    if (bus.ZHighIn) zhi  <= alu[63:32];
    if (bus.LOin)    lo_r <= dbus;
    if (bus.HIin)    hi_r <= dbus;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Architectural meaning of each operation: {HI, LO}; DIV puts the remainder in HI.
  function automatic logic [63:0] ref_exec(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      OP_ADD:  return {32'd0, a + b};
      OP_SUB:  return {32'd0, a - b};
      OP_AND:  return {32'd0, a & b};
      OP_OR:   return {32'd0, a | b};
      OP_MUL:  return 64'(a) * 64'(b);
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic out_t sample();
    out_t a;
    a.PCout = bus.PCout;   a.PCin = bus.PCin;     a.IncPC = bus.IncPC;
    a.MARin = bus.MARin;   a.Read = bus.Read;     a.MDRin = bus.MDRin;
    a.MDRout = bus.MDRout; a.IRin = bus.IRin;     a.Yin = bus.Yin;
    a.ZLowIn = bus.ZLowIn; a.ZHighIn = bus.ZHighIn;
    a.Zlowout = bus.Zlowout; a.Zhighout = bus.Zhighout;
    a.HIin = bus.HIin;     a.LOin = bus.LOin;
    a.reg_out_en = bus.reg_out_en; a.reg_in_en = bus.reg_in_en;
    a.reg_sel = bus.reg_sel; a.opcode = bus.opcode;
    a.done = bus.done;     a.halted = bus.halted; a.fault = bus.fault;
    return a;
  endfunction

  // One clock cycle: inputs for this cycle plus the outputs this cycle must show.
  task automatic step(input logic clr, input logic rn, input logic mr,
                      input logic [31:0] irv, input out_t e);
    @(posedge clock);
    #1;
    clear       = clr;
    bus.run     = rn;
    bus.mem_rdy = mr;
    bus.ir      = irv;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input logic rn);
    step(1'b0, rn, rbit(), $urandom(), '0);
  endtask

  // Runs one instruction from T0. res: 0 done, 1 halted, 2 faulted, 3 cleared early.
  task automatic do_instr(input logic [31:0] iv, input int k, input logic run_hold,
                          input int clear_at, output int res);
    cyc_t        plan[$];
    cyc_t        c;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        legal, wide, last;
    logic [63:0] r;
    res_t        rv;
    int          t3;
    op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
    wide  = op inside {OP_MUL, OP_DIV};
    legal = wide || (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});

    c.e = '0; c.mr = rbit();
    c.e.PCout = 1'b1; c.e.MARin = 1'b1; c.e.IncPC = 1'b1; c.e.PCin = 1'b1;
    plan.push_back(c);
    for (int i = 0; i <= k; i++) begin
      c.e = '0; c.mr = (i == k);
      c.e.Read = 1'b1; c.e.MDRin = 1'b1;
      plan.push_back(c);
    end
    c.e = '0; c.mr = rbit(); c.e.MDRout = 1'b1; c.e.IRin = 1'b1;
    plan.push_back(c);
    t3 = plan.size();
    c.e = '0; c.mr = rbit();
    if (legal) begin
      c.e.reg_out_en = 1'b1; c.e.reg_sel = rb; c.e.Yin = 1'b1;
    end
    plan.push_back(c);
    if (legal) begin
      c.e = '0; c.mr = rbit();
      c.e.reg_out_en = 1'b1; c.e.reg_sel = rc; c.e.opcode = op;
      c.e.ZLowIn = 1'b1; c.e.ZHighIn = 1'b1;
      plan.push_back(c);
      c.e = '0; c.mr = rbit(); c.e.Zlowout = 1'b1;
      if (wide) c.e.LOin = 1'b1;
      else begin c.e.reg_in_en = 1'b1; c.e.reg_sel = ra; c.e.done = 1'b1; end
      plan.push_back(c);
      if (wide) begin
        c.e = '0; c.mr = rbit();
        c.e.Zhighout = 1'b1; c.e.HIin = 1'b1; c.e.done = 1'b1;
        plan.push_back(c);
      end
    end

    res = legal ? 0 : ((op == OP_HALT) ? 1 : 2);
    foreach (plan[i]) begin
      last = (i == plan.size() - 1);
      if (last && legal) begin
        r = ref_exec(op, model_regs[rb], model_regs[rc]);
        rv.wide = wide; rv.ra = ra; rv.lo = r[31:0]; rv.hi = r[63:32];
        res_q.push_back(rv);
        if (!wide) model_regs[ra] = r[31:0];
      end
      step(i == clear_at, (last && legal) ? run_hold : rbit(), plan[i].mr,
           (i >= t3) ? iv : $urandom(), plan[i].e);
      if (i == clear_at) begin
        res = 3;
        return;
      end
    end
  endtask

  task automatic trap_hold(input int kind, input int m);
    out_t e;
    e = '0;
    if (kind == 1) e.halted = 1'b1;
    else           e.fault  = 1'b1;
    repeat (m) step(1'b0, 1'b1, rbit(), $urandom(), e);
    step(1'b1, 1'b1, rbit(), $urandom(), e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops [6];
    logic [31:0] iv;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
    iv = $urandom();
    iv[31:27] = ops[$urandom_range(0, 5)];
    if (iv[31:27] == OP_DIV && model_regs[iv[18:15]] == 32'd0) iv[31:27] = OP_MUL;
    return iv;
  endfunction

  function automatic logic [31:0] rand_bad();
    logic [31:0] iv;
    iv = $urandom();
    if (rbit()) iv[31:27] = OP_HALT;
    else if (iv[31:27] inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_HALT})
      iv[31:27] = 5'b11111;
    return iv;
  endfunction

  // Monitor: one expected output vector per cycle, plus results one cycle after done.
  initial begin
    out_t a, e;
    res_t rv;
    int   ndrv;
    forever begin
      @(negedge clock);
      if (res_pending) begin
        res_pending = 1'b0;
        check("result_present", 64'(res_q.size() > 0), 64'd1);
        if (res_q.size() > 0) begin
          rv = res_q.pop_front();
          if (rv.wide) begin
            check("lo_result", 64'(lo_r), 64'(rv.lo));
            check("hi_result", 64'(hi_r), 64'(rv.hi));
          end else begin
            check("reg_write", 64'(regs[rv.ra]), 64'(rv.lo));
          end
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        check("outputs", 64'(a), 64'(e));
        ndrv = int'(a.PCout) + int'(a.MDRout) + int'(a.reg_out_en)
             + int'(a.Zlowout) + int'(a.Zhighout);
        check("single_bus_driver", 64'(ndrv <= 1), 64'd1);
        res_pending = (a.done === 1'b1);
      end
    end
  end

  initial begin
    int          res, k, clear_at;
    logic [31:0] iv;
    logic        hold;
    bit          in_t0;
    clear = 1'b1; bus.run = 1'b0; bus.mem_rdy = 1'b0; bus.ir = '0; init_regs = 1'b1;
    for (int i = 0; i < 16; i++) init_val[i] = $urandom_range(1, 32'h00FF_FFFF);
    init_val[3] = 32'h18;
    init_val[7] = 32'h14;
    for (int i = 0; i < 16; i++) model_regs[i] = init_val[i];

    step(1'b0, 1'b0, 1'b0, '0, '0);
    init_regs = 1'b0;

    idle_cycle(1'b1); do_instr(32'h221B8000, 0, 1'b0, -1, res); idle_cycle(1'b0);
    idle_cycle(1'b1); do_instr(32'h18A30000, 3, 1'b0, -1, res); idle_cycle(1'b0);
    idle_cycle(1'b1); do_instr(32'h18A30000, 1, 1'b1, 5, res);  idle_cycle(1'b0);
    idle_cycle(1'b1); do_instr(32'h7A1B8000, 0, 1'b1, -1, res);
    do_instr(32'h18A30000, 0, 1'b0, -1, res); idle_cycle(1'b0);
    idle_cycle(1'b1); do_instr(32'hF8000000, 0, 1'b1, -1, res);
    trap_hold(2, 10); idle_cycle(1'b0);
    idle_cycle(1'b1); do_instr(32'hD8000000, 1, 1'b1, -1, res);
    trap_hold(1, 6); idle_cycle(1'b0);

    in_t0 = 1'b0;
    repeat (40) begin
      if (!in_t0) begin
        repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
      iv       = ($urandom_range(0, 9) == 0) ? rand_bad() : rand_instr();
      k        = $urandom_range(0, 3);
      hold     = rbit();
      clear_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, k + 6)) : -1;
      do_instr(iv, k, hold, clear_at, res);
      case (res)
        0:       in_t0 = hold;
        1, 2:    begin trap_hold(res, $urandom_range(1, 3)); in_t0 = 1'b0; end
        default: in_t0 = 1'b0;
      endcase
    end
    if (in_t0) do_instr(rand_instr(), 0, 1'b0, -1, res);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    for (int i = 0; i < 20 && (exp_q.size() > 0 || res_pending); i++) begin
      @(negedge clock);
      #1;
    end
    check("scoreboard_drained", 64'(exp_q.size() + res_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the `DataPath` strobes for instruction fetch and three-operand ALU execution (add, sub, and, or, mul, div). It replaces bench-driven T0–T6 sequencing with a synthesizable Moore FSM. Inputs are the IR contents and a memory-ready handshake. Outputs are the register-transfer strobes, a 4-bit register select, and the ALU opcode, all wired directly to the datapath.

## Interface
Parameters:
- `OP_W`, default 5, opcode width (IR[31:27]).
- `REG_W`, default 4, register-field width.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `run`  in  1  level; while high, the sequencer fetches the next instruction.
- `mem_rdy`  in  1  memory data valid during T1.
- `ir`  in  32  datapath IR contents, stable from T3 onward.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`  out  1 each  datapath strobes.
- `ZLowIn`, `ZHighIn`, `Zlowout`, `Zhighout`, `HIin`, `LOin`  out  1 each  Z/HI/LO strobes.
- `reg_out_en`, `reg_in_en`  out  1 each  general-register bus drive and load enables.
- `reg_sel`  out  4  register index for the active `reg_out_en` or `reg_in_en`.
- `opcode`  out  5  ALU operation; 0 outside T4.
- `done`  out  1  one-cycle pulse in the final step of each instruction.
- `halted`, `fault`  out  1 each  sticky status flags.

## Operation
- Fields:
  - op = `ir[31:27]`
  - ra = `ir[26:23]`
  - rb = `ir[22:19]`
  - rc = `ir[18:15]`
- Legal ops:
  - ALU: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR.
  - Wide: 01111 MUL, 10000 DIV.
  - 11011 HALT.
  - Everything else is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT.
- Moore outputs. Every strobe not listed for a state is 0.
  - IDLE: no strobes. Goes to T0 when `run`=1.
  - T0: `PCout`, `MARin`, `IncPC`, `PCin`. Goes to T1.
  - T1: `Read`, `MDRin`. Stays in T1 while `mem_rdy`=0; goes to T2 when `mem_rdy`=1.
  - T2: `MDRout`, `IRin`. Goes to T3.
  - T3, legal ALU or wide op: `reg_out_en`, `reg_sel`=rb, `Yin`; goes to T4.
  - T3, HALT op: no strobes; goes to HALT.
  - T3, illegal op: no strobes; goes to FAULT.
  - T4: `reg_out_en`, `reg_sel`=rc, `opcode`=op, `ZLowIn`, `ZHighIn`. Goes to T5.
  - T5, ALU op: `Zlowout`, `reg_in_en`, `reg_sel`=ra, `done`. Next state is T0 if `run`=1, else IDLE.
  - T5, MUL/DIV: `Zlowout`, `LOin`, `reg_in_en`=0. Goes to T6.
  - T6: `Zhighout`, `HIin`, `done`. Next state is T0 if `run`=1, else IDLE.
  - HALT: `halted`=1. Leaves only on `clear`.
  - FAULT: `fault`=1. Leaves only on `clear`.
- `run` is sampled only in IDLE, T5 (ALU op) and T6. Deasserting `run` mid-instruction completes the current instruction.
- `reg_sel` is 0 when neither `reg_out_en` nor `reg_in_en` is high.
- At most one bus driver is active per cycle. The 32-bit bus must never see two sources.

## Timing
- `clear`=1 at a rising edge puts the FSM in IDLE on the next cycle, from any state including mid-T1. This is synchronous: `clear` has no effect between edges.
- While in IDLE, every output is 0, including `halted` and `fault`.
- `clear` has priority over `run` and `mem_rdy`.
- Latency from `run` seen in IDLE to `done`, with k = number of cycles `mem_rdy` is low in T1:
  - ALU op: 6 + k cycles (T0..T5).
  - MUL/DIV: 7 + k cycles (T0..T6).
- Back-to-back instructions: the cycle after `done` is T0. There is no bubble.
- `ir` is decoded combinationally in T3–T6. IR is loaded at the end of T2, so T3 sees the new value.
- `mem_rdy` is ignored outside T1.
- If `mem_rdy` is high on the first T1 cycle, T1 lasts exactly one cycle.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `clear` for 1 cycle during T4.
  - Response: next cycle is IDLE with all outputs 0, and `opcode`=0.
- SUB, `ir`=0x221B8000, `mem_rdy`=1, `run` pulsed for 1 cycle:
  - T3: `reg_sel`=3, `Yin`=1.
  - T4: `reg_sel`=7, `opcode`=00100.
  - T5: `reg_sel`=4, `reg_in_en`=1, `done`=1.
  - Then IDLE.
  - With datapath R3=0x18 and R7=0x14, R4 ends at 0x4.
- Memory wait:
  - Stimulus: `mem_rdy` low for 3 cycles in T1.
  - Response: `Read`/`MDRin` held for 4 cycles; `done` at cycle 9.
- MUL, `ir`=0x7A1B8000:
  - T5: `LOin`=1, `reg_in_en`=0.
  - T6: `Zhighout`=1, `HIin`=1, `done`=1.
  - With `run` held high, T0 follows immediately.
- Illegal op 11111:
  - T3 asserts no strobes, then FAULT with `fault`=1.
  - Stays in FAULT for 10 cycles with `run`=1.
  - `clear` returns it to IDLE.
- HALT op 11011:
  - Reaches HALT with `halted`=1 and no further fetch (`PCout` stays 0) despite `run`=1.
